digit_serial_add_ctrl: RTL and testbench

DIGIT_SERIAL_ADD_CTRL -- requirements
Module: digit_serial_add_ctrl

---
 rtl/digit_serial_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_digit_serial_add_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial adder/subtractor: one shared 4-bit carry-lookahead slice processes
// WIDTH/4 nibbles LSB first, under a three-state IDLE/ADD/DONE controller.
module digit_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [IdxW+1:0]  base;
    logic [3:0]       nib_a, nib_b, g, p, sum;
    logic [4:0]       c;
    logic             last;

    assign base = {idx_q, 2'b00};
    assign last = (idx_q == IdxW'(N - 1));

    // Shared 4-bit carry-lookahead slice
    always_comb begin
        nib_a = a_q[base +: 4];
        nib_b = b_q[base +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum   = p ^ c[3:0];
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Run)  state_d = StAdd;
            StAdd:   if (last) state_d = StDone;
            StDone:  if (!Run) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register alone
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state_q)
            StAdd:   Busy = 1'b1;
            StDone:  Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state; subtraction is A + ~B + 1 with the +1 seeded as carry-in
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (Run) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Sub}};
                    carry_d = Sub;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            StAdd: begin
                s_d[base +: 4] = sum;
                carry_d        = c[4];
                idx_d          = idx_q + IdxW'(1);
                if (last) begin
                    cout_d = c[4];
                    ovf_d  = c[3] ^ c[4];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Self-checking bench for digit_serial_add_ctrl (WIDTH=16): directed vector table,
// multi-cycle corner sequences, and random operations against an arithmetic model.
module tb_digit_serial_add_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             Clk;
    logic             Reset_n;
    logic             Run;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;

    digit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Run     (Run),
        .Sub     (Sub),
        .A       (A),
        .B       (B),
        .S       (S),
        .Cout    (Cout),
        .Ovf     (Ovf),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: signed/unsigned integer arithmetic on the operands
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] s, output logic c, output logic o);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        s  = ur[15:0];
        c  = sub ? (ua >= ub) : (ur > 65535);
        o  = (sr > 32767) || (sr < -32768);
    endtask

    // One operation with a single-cycle Run pulse; operands scrambled right after capture
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] s, output logic c, output logic o,
                         output int lat);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Run = 1'b0;
        A   = 16'($urandom);
        B   = 16'($urandom);
        Sub = ~sub;
        chk("busy_after_capture", {31'd0, Busy}, 32'd1);
        lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        chk("busy_low_in_done", {31'd0, Busy}, 32'd0);
        s = S; c = Cout; o = Ovf;
        @(posedge Clk);
        @(negedge Clk);
        chk("done_clears", {31'd0, Done}, 32'd0);
    endtask

    initial begin
        logic [15:0] rs, es;
        logic        rc, ro, ec, eo;
        int          lat;
        int          busy_cnt, done_cnt, both_cnt;
        logic [15:0] ra, rb;
        logic        rsub;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        Reset_n = 1'b0; Run = 1'b0; Sub = 1'b0; A = '0; B = '0;
        #3;
        chk("reset_S", {16'd0, S}, 32'd0);
        chk("reset_Cout", {31'd0, Cout}, 32'd0);
        chk("reset_Ovf", {31'd0, Ovf}, 32'd0);
        chk("reset_Busy", {31'd0, Busy}, 32'd0);
        chk("reset_Done", {31'd0, Done}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_no_start", {30'd0, Busy, Done}, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, lat);
            chk("vec_latency", lat, 32'd4);
            chk("vec_S", {16'd0, rs}, {16'd0, vecs[i].s});
            chk("vec_Cout", {31'd0, rc}, {31'd0, vecs[i].c});
            chk("vec_Ovf", {31'd0, ro}, {31'd0, vecs[i].o});
        end

        // IDLE holds the last result while inputs wander
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom);
            chk("idle_hold_S", {16'd0, S}, {16'd0, vecs[7].s});
            chk("idle_hold_flags", {30'd0, Busy, Done}, 32'd0);
        end

        // Run held high for 10 cycles: one operation only, Done sticks until Run drops
        @(negedge Clk);
        A = 16'h1111; B = 16'h2222; Sub = 1'b0; Run = 1'b1;
        busy_cnt = 0; done_cnt = 0; both_cnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (cyc == 1) begin
                A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1;
            end
            busy_cnt += int'(Busy);
            done_cnt += int'(Done);
            both_cnt += int'(Busy & Done);
        end
        chk("held_busy_cycles", busy_cnt, 32'd4);
        chk("held_done_cycles", done_cnt, 32'd6);
        chk("held_busy_and_done", both_cnt, 32'd0);
        chk("held_S", {16'd0, S}, 32'h3333);
        chk("held_flags", {30'd0, Cout, Ovf}, 32'd0);
        Run = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("held_to_idle", {30'd0, Busy, Done}, 32'd0);
        chk("held_S_in_idle", {16'd0, S}, 32'h3333);

        // Asynchronous reset between edges in the 2nd ADD cycle
        @(negedge Clk);
        A = 16'h1234; B = 16'h4321; Sub = 1'b0; Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("abort_S", {16'd0, S}, 32'd0);
        chk("abort_flags", {28'd0, Cout, Ovf, Busy, Done}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_stays_idle", {30'd0, Busy, Done}, 32'd0);
        do_op(16'hFFFF, 16'h0001, 1'b0, rs, rc, ro, lat);
        chk("post_reset_latency", lat, 32'd4);
        chk("post_reset_S", {16'd0, rs}, 32'd0);
        chk("post_reset_flags", {30'd0, rc, ro}, 32'd2);

        // Random operations against the model
        for (int k = 0; k < 30; k++) begin
            ra   = 16'($urandom);
            rb   = (k % 5 == 0) ? ra : 16'($urandom);
            rsub = 1'($urandom_range(0, 1));
            model(ra, rb, rsub, es, ec, eo);
            do_op(ra, rb, rsub, rs, rc, ro, lat);
            chk("rand_latency", lat, 32'd4);
            chk("rand_S", {16'd0, rs}, {16'd0, es});
            chk("rand_Cout", {31'd0, rc}, {31'd0, ec});
            chk("rand_Ovf", {31'd0, ro}, {31'd0, eo});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
